// File: rtl/temp_channel_scheduler.sv
// Purpose : round-robin arbiter sharing one temperature calculator between 4 sensor channels.
// Latency : grant one edge after req is seen, result/ack SETTLE edges later (SETTLE+1 cycles per conversion).
// Backpressure: requesters hold req until their one-cycle ack; req is ignored while a conversion is in flight.
//
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   req[3:0]           - per-channel conversion request
//   sensor_val[15:0]   - channel i nibble on [4i+3:4i]
//   calc_sensor[3:0]   - registered operand to the shared calculator
//   calc_temp[7:0]     - combinational calculator result
//   limit[7:0]         - over-temperature threshold (unsigned)
//   ack[3:0]           - one-hot completion pulse to the served channel
//   temp_out/temp_ch   - last captured temperature and its channel
//   temp_valid         - one-cycle pulse when temp_out/temp_ch update
//   over_temp          - last captured temp_out > limit
//   busy               - conversion in progress
module temp_channel_scheduler #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] sensor_val,
    output logic [3:0]  calc_sensor,
    input  logic [7:0]  calc_temp,
    input  logic [7:0]  limit,
    output logic [3:0]  ack,
    output logic [7:0]  temp_out,
    output logic [1:0]  temp_ch,
    output logic        temp_valid,
    output logic        over_temp,
    output logic        busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] lastCh;
    logic [1:0] grantCh;
    logic [3:0] settleCnt;

    logic [1:0] pickCh;
    logic [3:0] pickNibble;

    // Round-robin search starting just after the last granted channel.
    // Offset 4 wraps back to lastCh itself, so a lone requester is re-granted.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        pickCh = lastCh;
        found  = 1'b0;
        cand   = lastCh;
        for (int k = 1; k <= 4; k++) begin
            cand = lastCh + 2'(k);
            if (!found && req[cand]) begin
                pickCh = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        pickNibble = 4'd0;
        case (pickCh)
            2'd0: pickNibble = sensor_val[3:0];
            2'd1: pickNibble = sensor_val[7:4];
            2'd2: pickNibble = sensor_val[11:8];
            2'd3: pickNibble = sensor_val[15:12];
            default: pickNibble = 4'd0;
        endcase
    end

    assign busy = (state == CALC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            calc_sensor <= 4'd0;
            temp_out    <= 8'd0;
            temp_ch     <= 2'd0;
            temp_valid  <= 1'b0;
            ack         <= 4'd0;
            over_temp   <= 1'b0;
            settleCnt   <= 4'd0;
            grantCh     <= 2'd0;
            lastCh      <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    // Pulses from the previous capture last exactly one cycle.
                    temp_valid <= 1'b0;
                    ack        <= 4'd0;
                    if (req != 4'd0) begin
                        calc_sensor <= pickNibble;
                        grantCh     <= pickCh;
                        lastCh      <= pickCh;
                        settleCnt   <= SETTLE_LOAD;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    // Operand is frozen in calc_sensor, so req/sensor_val changes
                    // here cannot disturb the conversion.
                    if (settleCnt == 4'd0) begin
                        temp_out   <= calc_temp;
                        temp_ch    <= grantCh;
                        temp_valid <= 1'b1;
                        ack        <= 4'b0001 << grantCh;
                        over_temp  <= (calc_temp > limit);
                        state      <= IDLE;
                    end else begin
                        settleCnt <= settleCnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_channel_scheduler.sv
module tb_temp_channel_scheduler;

    localparam int COEF = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] sensor_val;
    logic [7:0]  limit;
    int          base;

    logic [3:0]  calcSensorA, calcSensorB;
    logic [7:0]  calcTempA, calcTempB;
    logic [3:0]  ackA, ackB;
    logic [7:0]  tempOutA, tempOutB;
    logic [1:0]  tempChA, tempChB;
    logic        tempValidA, tempValidB;
    logic        overTempA, overTempB;
    logic        busyA, busyB;

    int nAsserts;
    int nFail;

    // Shared calculator models: base + sensor*coef, mod 256
    assign calcTempA = 8'((base + int'(calcSensorA) * COEF) % 256);
    assign calcTempB = 8'((base + int'(calcSensorB) * COEF) % 256);

    temp_channel_scheduler #(.SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sensor_val(sensor_val),
        .calc_sensor(calcSensorA), .calc_temp(calcTempA), .limit(limit),
        .ack(ackA), .temp_out(tempOutA), .temp_ch(tempChA),
        .temp_valid(tempValidA), .over_temp(overTempA), .busy(busyA)
    );

    temp_channel_scheduler #(.SETTLE(3)) dutB (
        .clk(clk), .rst_n(rst_n), .req(req), .sensor_val(sensor_val),
        .calc_sensor(calcSensorB), .calc_temp(calcTempB), .limit(limit),
        .ack(ackB), .temp_out(tempOutB), .temp_ch(tempChB),
        .temp_valid(tempValidB), .over_temp(overTempB), .busy(busyB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level reference: one outstanding conversion per scheduler.
    bit         mBusy[2];
    int         mLeft[2];
    int         mLast[2];
    int         mG[2];
    logic [3:0] mSens[2];
    logic [7:0] eTemp[2];
    logic [1:0] eCh[2];
    logic       eValid[2];
    logic [3:0] eAck[2];
    logic       eOver[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mBusy[m] = 0; mLeft[m] = 0; mLast[m] = 3; mG[m] = 0;
            mSens[m] = 4'd0; eTemp[m] = 8'd0; eCh[m] = 2'd0;
            eValid[m] = 1'b0; eAck[m] = 4'd0; eOver[m] = 1'b0;
        end
    endtask

    // Predict the effect of the coming rising edge given the inputs now applied.
    task automatic modelStep(input int m);
        int  settle;
        bit  found;
        int  c;
        settle = (m == 0) ? 1 : 3;
        eValid[m] = 1'b0;
        eAck[m]   = 4'd0;
        if (mBusy[m]) begin
            if (mLeft[m] == 0) begin
                eTemp[m]  = 8'((base + int'(mSens[m]) * COEF) % 256);
                eCh[m]    = 2'(mG[m]);
                eValid[m] = 1'b1;
                eAck[m]   = 4'(1 << mG[m]);
                eOver[m]  = (int'(eTemp[m]) > int'(limit));
                mBusy[m]  = 0;
            end else begin
                mLeft[m] = mLeft[m] - 1;
            end
        end else if (req != 4'd0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                c = (mLast[m] + k) % 4;
                if (!found && req[c]) begin
                    mG[m] = c;
                    found = 1;
                end
            end
            mSens[m] = sensor_val[4 * mG[m] +: 4];
            mLeft[m] = settle - 1;
            mBusy[m] = 1;
            mLast[m] = mG[m];
        end
    endtask

    task automatic checkAll();
        chk("a_calc_sensor", calcSensorA, mSens[0]);
        chk("a_ack",         ackA,        eAck[0]);
        chk("a_temp_out",    tempOutA,    eTemp[0]);
        chk("a_temp_ch",     tempChA,     eCh[0]);
        chk("a_temp_valid",  tempValidA,  eValid[0]);
        chk("a_over_temp",   overTempA,   eOver[0]);
        chk("a_busy",        busyA,       mBusy[0]);
        chk("b_calc_sensor", calcSensorB, mSens[1]);
        chk("b_ack",         ackB,        eAck[1]);
        chk("b_temp_out",    tempOutB,    eTemp[1]);
        chk("b_temp_ch",     tempChB,     eCh[1]);
        chk("b_temp_valid",  tempValidB,  eValid[1]);
        chk("b_over_temp",   overTempB,   eOver[1]);
        chk("b_busy",        busyB,       mBusy[1]);
    endtask

    // One clock: apply inputs, predict, then sample on the falling edge.
    task automatic cyc(input logic [3:0] r, input logic [15:0] s);
        req = r;
        sensor_val = s;
        modelStep(0);
        modelStep(1);
        @(negedge clk);
        checkAll();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0, 16'd0);
    endtask

    // Called on a falling edge; reset takes effect without waiting for a clock.
    task automatic doReset();
        req = 4'd0;
        rst_n = 1'b0;
        #1;
        modelReset();
        chk("rst_a_outputs", {calcSensorA, ackA, tempOutA, tempChA, tempValidA, overTempA, busyA}, 32'd0);
        chk("rst_b_outputs", {calcSensorB, ackB, tempOutB, tempChB, tempValidB, overTempB, busyB}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runReq(input logic [3:0] r, input logic [15:0] s, input string tag);
        int  lat;
        bit  done;
        lat = -1;
        done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                cyc(r, s);
                if ((ackA & r) != 4'd0) begin
                    lat = i + 1;
                    done = 1;
                end
            end
        end
        chk({tag, "_latency"}, lat, 2);
    endtask

    function automatic int idxOf(input logic [3:0] a);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (a[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [3:0] reqCur;
        logic [3:0] ackSeq[2];
        logic [7:0] tSeq[2];
        int         tIdx[2];
        int         nA;
        int         lastChA, lastTA, lastChB, lastTB, busyCnt, win;
        bit         seenB;

        nAsserts = 0;
        nFail = 0;
        base = 20;
        limit = 8'd255;
        req = 4'd0;
        sensor_val = 16'd0;
        rst_n = 1'b0;
        modelReset();

        #1;
        doReset();

        // Single request on channel 0, value 5
        cyc(4'b0001, 16'h0005);
        chk("r28_calc_sensor", calcSensorA, 4'd5);
        chk("r28_busy", busyA, 1'b1);
        cyc(4'b0001, 16'h0005);
        chk("r28_ack", ackA, 4'b0001);
        chk("r28_valid", tempValidA, 1'b1);
        chk("r28_temp", tempOutA, 8'd35);
        chk("r28_ch", tempChA, 2'd0);
        cyc(4'b0000, 16'h0005);
        chk("r28_ack_pulse_end", ackA, 4'd0);
        drain(4);

        // Two requesters, each released on its own ack
        doReset();
        reqCur = 4'b0101;
        nA = 0;
        for (int i = 0; i < 2; i++) begin ackSeq[i] = 4'd0; tSeq[i] = 8'd0; tIdx[i] = 0; end
        for (int i = 0; i < 12; i++) begin
            cyc(reqCur, 16'h0402);
            if (ackA != 4'd0 && nA < 2) begin
                ackSeq[nA] = ackA;
                tSeq[nA] = tempOutA;
                tIdx[nA] = i;
                nA++;
                reqCur = reqCur & ~ackA;
            end
        end
        chk("r29_ack_count", nA, 2);
        chk("r29_ack0", ackSeq[0], 4'b0001);
        chk("r29_ack1", ackSeq[1], 4'b0100);
        chk("r29_temp0", tSeq[0], 8'd26);
        chk("r29_temp1", tSeq[1], 8'd32);
        chk("r29_first_lat", tIdx[0], 1);
        chk("r29_gap", tIdx[1] - tIdx[0], 2);
        drain(4);

        // All channels requesting continuously
        lastChA = -1; lastTA = -1; lastChB = -1; lastTB = -1;
        busyCnt = 0; win = 0; seenB = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(4'b1111, 16'($urandom));
            if (ackA != 4'd0) begin
                if (lastTA >= 0) begin
                    chk("r30a_order", idxOf(ackA), (lastChA + 1) % 4);
                    chk("r30a_period", i - lastTA, 2);
                end
                lastChA = idxOf(ackA);
                lastTA = i;
            end
            if (ackB != 4'd0) begin
                if (lastTB >= 0) begin
                    chk("r30b_order", idxOf(ackB), (lastChB + 1) % 4);
                    chk("r30b_period", i - lastTB, 4);
                end
                lastChB = idxOf(ackB);
                lastTB = i;
            end
            if (seenB && win < 16) begin
                busyCnt += int'(busyB);
                win++;
            end
            if (ackB != 4'd0) seenB = 1;
        end
        chk("r30b_busy_3_of_4", busyCnt, 12);
        drain(5);

        // Threshold and wrap-around
        limit = 8'd35;
        runReq(4'b0001, 16'h0005, "r31_eq");
        chk("r31_eq_temp", tempOutA, 8'd35);
        chk("r31_eq_over", overTempA, 1'b0);
        drain(4);
        runReq(4'b0001, 16'h0006, "r31_gt");
        chk("r31_gt_temp", tempOutA, 8'd38);
        chk("r31_gt_over", overTempA, 1'b1);
        drain(4);
        base = 250;
        runReq(4'b0001, 16'h000F, "r31_wrap");
        chk("r31_wrap_temp", tempOutA, 8'd39);
        chk("r31_wrap_over", overTempA, 1'b1);
        drain(4);
        chk("r31_over_hold", overTempA, 1'b1);
        base = 20;

        // Reset in the middle of a conversion
        cyc(4'b0001, 16'h0007);
        chk("r32_busy_before", busyA, 1'b1);
        doReset();
        chk("r32_no_ack", ackA, 4'd0);
        runReq(4'b0010, 16'h0070, "r32_regrant");
        chk("r32_ack", ackA, 4'b0010);
        chk("r32_temp", tempOutA, 8'd41);
        chk("r32_ch", tempChA, 2'd1);
        drain(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            limit = 8'($urandom_range(0, 255));
            cyc(4'($urandom_range(0, 15)), 16'($urandom));
        end
        drain(5);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/temp_channel_scheduler.md
TEMP_CHANNEL_SCHEDULER -- requirements
Module: temp_channel_scheduler

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of cycles (1..15) the operand is held on the shared calculator before its result is captured.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 4 bits: per-channel conversion request, channel i on bit i.
REQ-005 The block SHALL have port sensor_val, input, 16 bits: channel i raw 4-bit sensor value on bits [4i+3:4i].
REQ-006 The block SHALL have port calc_sensor, output, 4 bits: registered operand driven to the shared temperature calculator's sensor input.
REQ-007 The block SHALL have port calc_temp, input, 8 bits: combinational result from the shared calculator (base + sensor*coef, mod 256).
REQ-008 The block SHALL have port limit, input, 8 bits: over-temperature threshold, unsigned.
REQ-009 The block SHALL have port ack, output, 4 bits: one-hot, one-cycle completion pulse to the served channel.
REQ-010 The block SHALL have port temp_out, output, 8 bits: last captured temperature.
REQ-011 The block SHALL have port temp_ch, output, 2 bits: channel index of temp_out.
REQ-012 The block SHALL have port temp_valid, output, 1 bit: one-cycle pulse, coincident with ack, when temp_out/temp_ch update.
REQ-013 The block SHALL have port over_temp, output, 1 bit: high when the last captured temp_out > limit at the capture edge.
REQ-014 The block SHALL have port busy, output, 1 bit: high while the FSM is in CALC.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and CALC.
REQ-016 In IDLE with req != 0, the block SHALL grant one channel by round-robin, searching from (last_ch+1) mod 4 upward with wrap-around, and enter CALC at that edge.
REQ-017 At the grant edge, the block SHALL latch that channel's nibble into calc_sensor, record the channel in a grant register, update last_ch, and load the settle counter to SETTLE-1.
REQ-018 In CALC, the settle counter SHALL decrement each cycle; on the edge where it equals 0, the block SHALL capture calc_temp into temp_out, set temp_ch, assert temp_valid and ack[grant] for exactly one cycle, update over_temp, and return to IDLE.
REQ-019 With SETTLE=1, the latency SHALL be: req seen at edge k -> CALC in cycle k+1 -> temp_valid/ack high in cycle k+2; one conversion occupies SETTLE+1 cycles.
REQ-020 In IDLE with req == 0, the block SHALL hold all state; calc_sensor SHALL keep its last value.
REQ-021 Requesters SHALL hold req until ack; if req drops while in CALC, the conversion SHALL still complete and ack SHALL still pulse.
REQ-022 A channel still requesting after its ack SHALL be re-granted only after all other requesting channels have been served (fairness).
REQ-023 Changes to sensor_val or req during CALC SHALL NOT affect the conversion in progress.
REQ-024 The over_temp comparison SHALL be unsigned and strict (temp_out == limit gives 0); over_temp SHALL hold its value between captures.
REQ-025 No more than one ack bit SHALL be high in any cycle; ack and temp_valid SHALL be low in every cycle not immediately following a capture edge.

Reset
REQ-026 While rst_n is low, the block SHALL force: state IDLE, calc_sensor 0, temp_out 0, temp_ch 0, temp_valid 0, ack 0, over_temp 0, busy 0, settle counter 0, and last_ch 3 so that channel 0 has first priority.
REQ-027 Reset asserted during CALC SHALL abort the conversion with no ack; after release, the FSM SHALL start in IDLE and grant afresh.

Verification
REQ-028 Bench calculator model base=20, coef=3, SETTLE=1: req=0001 with ch0=5 -> calc_sensor=5 in the next cycle; temp_valid, ack=0001, temp_out=35, temp_ch=0 two cycles after req is sampled.
REQ-029 After reset, req=0101 held with ch0=2 and ch2=4, releasing each req on its ack -> ack order 0001 then 0100, temp_out 26 then 32, with no idle gap beyond one IDLE cycle.
REQ-030 req=1111 held continuously -> grants 0,1,2,3,0,... each exactly every 2 cycles (SETTLE=1); with SETTLE=3, every 4 cycles and busy high 3 of 4 cycles.
REQ-031 limit=35: ch value 5 -> temp_out 35, over_temp=0; ch value 6 -> temp_out 38, over_temp=1; sensor 15 with base 250 -> temp_out 39 (mod 256 wrap).
REQ-032 rst_n pulsed low mid-CALC -> no ack, all outputs 0 immediately (asynchronous); after release with req=0010, ch1 is granted first and acked normally.
